// File: rtl/cond_issue_gate.sv
// ============================================================================
// Module   : cond_issue_gate
// Brief    : Multi-slot ARM condition evaluator with in-flight flag-writer
//            tracking, status-register bypass and optional output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_issue_gate #(
  parameter int NUM_SLOTS   = 1,
  parameter int MAX_PENDING = 3,
  parameter int PIPE_STAGE  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SLOTS-1:0]                 in_valid,
  input  logic [4*NUM_SLOTS-1:0]               in_cond,
  input  logic [NUM_SLOTS-1:0]                 in_sets_flags,
  output logic [NUM_SLOTS-1:0]                 in_take,
  input  logic                                 flag_wr_en,
  input  logic [3:0]                           flag_wr_val,
  input  logic                                 flush,
  output logic                                 out_valid,
  output logic [NUM_SLOTS-1:0]                 out_exec,
  input  logic                                 out_ready,
  output logic [3:0]                           sr_out,
  output logic [$clog2(MAX_PENDING+1)-1:0]     pending_cnt,
  output logic                                 err_underflow
);

  localparam int C_CW = $clog2(MAX_PENDING + 1);
  localparam int C_SW = 6;

  logic [3:0]           r_sr;
  logic [C_CW-1:0]      r_pend;
  logic                 r_err;

  logic [3:0]           w_flags_eff;
  logic [C_CW-1:0]      w_pend_eff;
  logic [C_CW-1:0]      w_pend_next;
  logic                 w_stage_free;
  logic                 w_go;
  logic                 w_prev;
  logic [C_SW-1:0]      w_setters;
  logic [NUM_SLOTS-1:0] w_take;
  logic [NUM_SLOTS-1:0] w_exec;

  // flags packed {Z,C,N,V}
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = ~z;
      4'h2:    eval_cond = c;
      4'h3:    eval_cond = ~c;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = ~n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = ~v;
      4'h8:    eval_cond = c & ~z;
      4'h9:    eval_cond = ~c | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = ~z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      default: eval_cond = 1'b1;
    endcase
  endfunction

  assign w_flags_eff = flag_wr_en ? flag_wr_val : r_sr;
  assign w_pend_eff  = (flag_wr_en && (r_pend != '0)) ? r_pend - C_CW'(1) : r_pend;
  assign w_go        = w_stage_free & ~flush & rst_n;

  // Prefix issue: the first slot that fails stops every slot above it.
  always_comb begin
    w_setters = '0;
    w_prev    = 1'b1;
    w_take    = '0;
    w_exec    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_prev && w_go && in_valid[i] &&
          ((in_cond[4*i+:4] == 4'hE) || (in_cond[4*i+:4] == 4'hF) ||
           ((w_pend_eff == '0) && (w_setters == '0))) &&
          (!in_sets_flags[i] ||
           ((C_SW'(w_pend_eff) + w_setters) < C_SW'(MAX_PENDING)))) begin
        w_take[i] = 1'b1;
        w_setters = w_setters + C_SW'(in_sets_flags[i]);
      end else begin
        w_prev = 1'b0;
      end
      w_exec[i] = eval_cond(in_cond[4*i+:4], w_flags_eff) & w_take[i];
    end
  end

  assign w_pend_next = flush ? '0 : C_CW'(C_SW'(w_pend_eff) + w_setters);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= 4'b0000;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      if (flag_wr_en) begin
        r_sr <= flag_wr_val;
      end
      if (flag_wr_en && (r_pend == '0)) begin
        r_err <= 1'b1;
      end
      r_pend <= w_pend_next;
    end
  end

  generate
    if (PIPE_STAGE != 0) begin : g_pipe
      logic                 r_out_valid;
      logic [NUM_SLOTS-1:0] r_out_exec;

      assign w_stage_free = ~r_out_valid | out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_valid <= 1'b0;
          r_out_exec  <= '0;
        end else if (flush) begin
          r_out_valid <= 1'b0;
          r_out_exec  <= '0;
        end else if (w_stage_free) begin
          r_out_valid <= |w_take;
          r_out_exec  <= w_exec;
        end
      end

      assign out_valid = r_out_valid;
      assign out_exec  = r_out_exec;
    end else begin : g_comb
      assign w_stage_free = out_ready;
      assign out_valid    = |w_take;
      assign out_exec     = w_exec;
    end
  endgenerate

  assign in_take       = w_take;
  assign sr_out        = r_sr;
  assign pending_cnt   = r_pend;
  assign err_underflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cond_issue_gate.sv
// ============================================================================
// Module   : tb_cond_issue_gate
// Brief    : Directed self-checking bench for cond_issue_gate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_issue_gate;

  logic       clk;
  logic       rst_n;

  // Two-slot registered instance
  logic [1:0] valid, sets, take, exec;
  logic [7:0] cond;
  logic       fw, flush, ov, ready, err;
  logic [3:0] fval, sr;
  logic [1:0] pend;

  // Single-slot combinational instance
  logic       c_valid, c_sets, c_take, c_exec, c_fw, c_ov, c_err;
  logic [3:0] c_cond, c_fval, c_sr;
  logic [1:0] c_pend;

  int n_vec;
  int n_err;

  cond_issue_gate #(.NUM_SLOTS(2), .MAX_PENDING(3), .PIPE_STAGE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid), .in_cond(cond), .in_sets_flags(sets),
    .in_take(take), .flag_wr_en(fw), .flag_wr_val(fval), .flush(flush),
    .out_valid(ov), .out_exec(exec), .out_ready(ready), .sr_out(sr),
    .pending_cnt(pend), .err_underflow(err)
  );

  cond_issue_gate #(.NUM_SLOTS(1), .MAX_PENDING(3), .PIPE_STAGE(0)) u_cmb (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_cond(c_cond), .in_sets_flags(c_sets),
    .in_take(c_take), .flag_wr_en(c_fw), .flag_wr_val(c_fval), .flush(1'b0),
    .out_valid(c_ov), .out_exec(c_exec), .out_ready(1'b1), .sr_out(c_sr),
    .pending_cnt(c_pend), .err_underflow(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden condition table built from the odd/even pairing of ARM codes.
  function automatic logic gold(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v, r;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? ~r : r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    valid = '0; cond = '0; sets = '0; fw = 1'b0; fval = '0; flush = 1'b0; ready = 1'b1;
    c_valid = 1'b0; c_cond = '0; c_sets = 1'b0; c_fw = 1'b0; c_fval = '0;
    tick(); tick();
    chk("rst_sr", 8'(sr), 8'h0);
    chk("rst_pend", 8'(pend), 8'h0);
    chk("rst_ov", 8'(ov), 8'h0);
    chk("rst_exec", 8'(exec), 8'h0);
    chk("rst_err", 8'(err), 8'h0);
    chk("rst_take", 8'(take), 8'h0);
    rst_n = 1'b1;
    tick();

    // EQ with Z=0 squashes; latency one cycle
    valid = 2'b01; cond = 8'h00; sets = 2'b00;
    #1 chk("t1_take", 8'(take), 8'h01);
    chk("t1_ov_pre", 8'(ov), 8'h0);
    tick();
    chk("t1_ov", 8'(ov), 8'h1);
    chk("t1_exec0", 8'(exec), 8'h0);
    valid = 2'b01; cond = 8'h0E; sets = 2'b01;
    #1 chk("t1_set_take", 8'(take), 8'h01);
    tick();
    chk("t1_pend1", 8'(pend), 8'h1);
    chk("t1_exec_al", 8'(exec), 8'h1);
    valid = 2'b00; sets = 2'b00; fw = 1'b1; fval = 4'b1000;
    tick();
    fw = 1'b0;
    chk("t1_sr", 8'(sr), 8'h8);
    chk("t1_pend0", 8'(pend), 8'h0);
    chk("t1_ov_idle", 8'(ov), 8'h0);
    valid = 2'b01; cond = 8'h00;
    #1 chk("t1_take2", 8'(take), 8'h01);
    tick();
    chk("t1_ov2", 8'(ov), 8'h1);
    chk("t1_exec1", 8'(exec), 8'h1);

    // Setter in slot0 blocks conditional slot1; bypass releases it
    valid = 2'b11; cond = 8'h1E; sets = 2'b01;
    #1 chk("t2_take", 8'(take), 8'h01);
    tick();
    chk("t2_pend", 8'(pend), 8'h1);
    chk("t2_exec", 8'(exec), 8'h1);
    valid = 2'b01; cond = 8'h01; sets = 2'b00;
    #1 chk("t2_stall", 8'(take), 8'h00);
    tick();
    chk("t2_stall_ov", 8'(ov), 8'h0);
    chk("t2_stall_pend", 8'(pend), 8'h1);
    fw = 1'b1; fval = 4'b0000;
    #1 chk("t2_bypass_take", 8'(take), 8'h01);
    tick();
    fw = 1'b0; valid = 2'b00;
    chk("t2_exec_ne", 8'(exec), 8'h1);
    chk("t2_sr", 8'(sr), 8'h0);
    chk("t2_pend0", 8'(pend), 8'h0);

    // Pending limit
    valid = 2'b01; cond = 8'h0E; sets = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_take", 8'(take), 8'h01);
      tick();
      chk("t4_pend", 8'(pend), 8'(k + 1));
    end
    #1 chk("t4_full_take", 8'(take), 8'h00);
    tick();
    chk("t4_full_pend", 8'(pend), 8'h3);
    fw = 1'b1; fval = 4'b0110;
    #1 chk("t4_retire_take", 8'(take), 8'h01);
    tick();
    chk("t4_pend_hold", 8'(pend), 8'h3);
    chk("t4_sr", 8'(sr), 8'h6);
    valid = 2'b00; sets = 2'b00;
    tick(); tick(); tick();
    fw = 1'b0;
    chk("t4_drain", 8'(pend), 8'h0);
    chk("t4_no_err", 8'(err), 8'h0);

    // Two setters in one cycle
    valid = 2'b11; cond = 8'hEE; sets = 2'b11;
    #1 chk("dual_take", 8'(take), 8'h03);
    tick();
    chk("dual_pend", 8'(pend), 8'h2);
    chk("dual_exec", 8'(exec), 8'h3);

    // Backpressure holds output
    ready = 1'b0; valid = 2'b01; cond = 8'h0E; sets = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t5_take", 8'(take), 8'h00);
      tick();
      chk("t5_ov", 8'(ov), 8'h1);
      chk("t5_exec", 8'(exec), 8'h3);
    end
    ready = 1'b1;
    #1 chk("t5_rel_take", 8'(take), 8'h01);
    tick();
    chk("t5_rel_exec", 8'(exec), 8'h1);
    valid = 2'b00;
    tick();
    chk("t5_drained", 8'(ov), 8'h0);
    chk("t5_pend", 8'(pend), 8'h2);

    // Flush with concurrent flag write
    flush = 1'b1; fw = 1'b1; fval = 4'b0100; valid = 2'b01; cond = 8'h0E;
    #1 chk("t6_flush_take", 8'(take), 8'h00);
    tick();
    flush = 1'b0; fw = 1'b0; valid = 2'b00;
    chk("t6_pend", 8'(pend), 8'h0);
    chk("t6_ov", 8'(ov), 8'h0);
    chk("t6_sr", 8'(sr), 8'h4);
    chk("t6_err0", 8'(err), 8'h0);
    fw = 1'b1; fval = 4'b1001;
    tick();
    fw = 1'b0;
    chk("t6_err1", 8'(err), 8'h1);
    chk("t6_uf_sr", 8'(sr), 8'h9);
    chk("t6_uf_pend", 8'(pend), 8'h0);

    // Async reset during a stall
    valid = 2'b01; cond = 8'h0E; sets = 2'b01;
    tick();
    valid = 2'b01; cond = 8'h00; sets = 2'b00;
    #1 chk("t6_stall", 8'(take), 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sr", 8'(sr), 8'h0);
    chk("ar_pend", 8'(pend), 8'h0);
    chk("ar_ov", 8'(ov), 8'h0);
    chk("ar_exec", 8'(exec), 8'h0);
    chk("ar_err", 8'(err), 8'h0);
    chk("ar_take", 8'(take), 8'h00);
    tick();
    valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // Full condition table on the combinational instance via bypass
    c_valid = 1'b1; c_fw = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        c_fval = 4'(f);
        c_cond = 4'(c);
        #1 chk("sweep", 8'(c_exec), 8'(gold(4'(c), 4'(f))));
      end
      chk("sweep_ov", 8'(c_ov), 8'h1);
    end
    c_cond = 4'h9; c_fval = 4'b1100;
    #1 chk("ls_c1z1", 8'(c_exec), 8'h1);
    c_fval = 4'b0000;
    #1 chk("ls_c0z0", 8'(c_exec), 8'h1);
    c_fval = 4'b0100;
    #1 chk("ls_c1z0", 8'(c_exec), 8'h0);
    c_valid = 1'b0; c_fw = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
